flash_page_cache: RTL and testbench

- Multi-page, read-only cache between the peripheral bus flash window and the QSPI flash reader.
- Holds PAGES pages of 2^PAGE_WORDS_LOG2 32-bit words each in one dual-port SRAM.
  - Port 0 is the fill port.
  - Port 1 is the bus read port.
- Misses are automatic: the block tags each slot, replaces round-robin, and serves a word as soon as that word has landed (critical-word-first is not required; fill is sequential from page start).

---
 rtl/flash_page_cache.sv | 245 ++++++++++++++++++++++++
 tb/tb_flash_page_cache.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_page_cache.sv
// flash_page_cache: multi-page read-only cache between the bus flash window
// and the QSPI flash reader. Pages live in one dual-port SRAM (port 0 fills,
// port 1 serves bus reads). Misses fill a round-robin victim slot sequentially
// from the page start, and a word is served as soon as it has landed.
// Optional FLASH_CACHE_PREFETCH_EN: after a demand fill completes, the next
// page (tag+1) is fetched into the victim slot when the bus is idle.
`timescale 1ns/1ps

module flash_page_cache #(
   parameter int unsigned PAGE_WORDS_LOG2 = 7,
   parameter int unsigned PAGES_LOG2 = 2,
   localparam int unsigned SRAM_ADDRESS_SIZE = PAGES_LOG2 + PAGE_WORDS_LOG2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         peripheralBus_we,
   input  logic                         peripheralBus_oe,
   input  logic [23:0]                  peripheralBus_address,
   input  logic [3:0]                   peripheralBus_byteSelect,
   input  logic [31:0]                  peripheralBus_dataWrite,
   output logic [31:0]                  peripheralBus_dataRead,
   output logic                         peripheralBus_busy,
   output logic                         qspi_enable,
   output logic [23:0]                  qspi_address,
   output logic                         qspi_changeAddress,
   output logic                         qspi_requestData,
   input  logic [31:0]                  qspi_readData,
   input  logic                         qspi_readDataValid,
   input  logic                         qspi_initialised,
   input  logic                         qspi_busy,
   output logic                         sram_clk0,
   output logic                         sram_csb0,
   output logic                         sram_web0,
   output logic [3:0]                   sram_wmask0,
   output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr0,
   output logic [31:0]                  sram_din0,
   output logic                         sram_clk1,
   output logic                         sram_csb1,
   output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr1,
   input  logic [31:0]                  sram_dout1
);

   localparam int unsigned TAG_W = 23 - PAGE_WORDS_LOG2 - 2;
   localparam int unsigned PAGES = 1 << PAGES_LOG2;
   localparam int unsigned CNT_W = PAGE_WORDS_LOG2 + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_FILL} state_t;

   state_t                 state;
   logic                   enable;
   logic [31:0]            miss_count;
   logic [PAGES-1:0]       valid;
   logic [TAG_W-1:0]       tags [PAGES];
   logic [TAG_W-1:0]       fill_tag;
   logic [PAGES_LOG2-1:0]  fill_slot;
   logic [PAGES_LOG2-1:0]  victim;
   logic [CNT_W-1:0]       fill_count;
   logic                   read_phase;

   logic [TAG_W-1:0]           tag;
   logic [PAGE_WORDS_LOG2-1:0] word;
   logic                       flash_rd, reg_rd, reg_wr, cfg_wr, inv_wr, enable_d;
   logic                       fill_active, fill_we, last_word;
   logic                       hit, miss, rd_issue, demand_start;
   logic [PAGES_LOG2-1:0]      hit_slot;
   logic [31:0]                status;
   logic                       unused_bits;

   // Address decode and register strobes
   assign tag      = peripheralBus_address[22:PAGE_WORDS_LOG2+2];
   assign word     = peripheralBus_address[PAGE_WORDS_LOG2+1:2];
   assign flash_rd = peripheralBus_oe && !peripheralBus_address[23];
   assign reg_rd   = peripheralBus_oe && (peripheralBus_address[23:12] == 12'h800);
   assign reg_wr   = peripheralBus_we && (peripheralBus_address[23:12] == 12'h800);
   assign cfg_wr   = reg_wr && (peripheralBus_address[11:0] == 12'h000) && peripheralBus_byteSelect[0];
   assign inv_wr   = reg_wr && (peripheralBus_address[11:0] == 12'h008);
   assign enable_d = cfg_wr ? peripheralBus_dataWrite[0] : enable;

   assign unused_bits = ^{peripheralBus_byteSelect[3:1], peripheralBus_dataWrite[31:1],
                          peripheralBus_address[1:0]};

   assign fill_active = (state == ST_FILL);
   assign fill_we     = fill_active && qspi_readDataValid;
   assign last_word   = (fill_count[PAGE_WORDS_LOG2-1:0] == '1);

   // Hit lookup: a valid slot with matching tag, or a word already landed in the slot being filled
   always_comb begin
      hit      = 1'b0;
      hit_slot = '0;
      for (int unsigned s = 0; s < PAGES; s++) begin
         if ((valid[s] && (tags[s] == tag)) ||
             (fill_active && (fill_slot == PAGES_LOG2'(s)) && (fill_tag == tag) &&
              (CNT_W'(word) < fill_count))) begin
            hit      = 1'b1;
            hit_slot = PAGES_LOG2'(s);
         end
      end
   end

   assign rd_issue     = flash_rd && !read_phase && hit;
   assign miss         = flash_rd && !read_phase && !hit;
   assign demand_start = (state == ST_IDLE) && miss && enable && qspi_initialised;

`ifdef FLASH_CACHE_PREFETCH_EN
   logic             pf_arm, pf_fill, pf_cached;
   logic [TAG_W-1:0] pf_tag;

   assign pf_tag = fill_tag + TAG_W'(1);

   // Skip the prefetch when the next page is already resident
   always_comb begin
      pf_cached = 1'b0;
      for (int unsigned s = 0; s < PAGES; s++) begin
         if (valid[s] && (tags[s] == pf_tag)) pf_cached = 1'b1;
      end
   end
`endif

   // SRAM ports: fill writes land straight from the reader, bus reads issue on a hit
   assign sram_clk0   = clk;
   assign sram_clk1   = clk;
   assign sram_csb0   = !fill_we;
   assign sram_web0   = !fill_we;
   assign sram_wmask0 = 4'hF;
   assign sram_addr0  = {fill_slot, fill_count[PAGE_WORDS_LOG2-1:0]};
   assign sram_din0   = qspi_readData;
   assign sram_csb1   = !rd_issue;
   assign sram_addr1  = {hit_slot, word};

   assign qspi_enable        = enable;
   assign peripheralBus_busy = flash_rd && !read_phase;
   assign status = {{(24 - PAGES_LOG2){1'b0}}, fill_slot, 6'd0, (state != ST_IDLE), qspi_initialised};

   // Read data: registers combinationally, flash words one cycle after the SRAM read
   always_comb begin
      peripheralBus_dataRead = '0;
      if (reg_rd) begin
         case (peripheralBus_address[11:0])
            12'h000: peripheralBus_dataRead = {31'd0, enable};
            12'h004: peripheralBus_dataRead = status;
            12'h00C: peripheralBus_dataRead = miss_count;
            default: peripheralBus_dataRead = '0;
         endcase
      end else if (flash_rd && read_phase) begin
         peripheralBus_dataRead = sram_dout1;
      end
   end

   // Fill FSM, slot bookkeeping and configuration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_IDLE;
         enable             <= 1'b0;
         miss_count         <= '0;
         valid              <= '0;
         for (int unsigned s = 0; s < PAGES; s++) tags[s] <= '0;
         fill_tag           <= '0;
         fill_slot          <= '0;
         victim             <= '0;
         fill_count         <= '0;
         read_phase         <= 1'b0;
         qspi_address       <= '0;
         qspi_changeAddress <= 1'b0;
         qspi_requestData   <= 1'b0;
`ifdef FLASH_CACHE_PREFETCH_EN
         pf_arm             <= 1'b0;
         pf_fill            <= 1'b0;
`endif
      end else begin
         qspi_changeAddress <= 1'b0;
         read_phase         <= rd_issue;
         if (cfg_wr) enable <= peripheralBus_dataWrite[0];

         case (state)
            ST_IDLE: begin
               if (demand_start) begin
                  fill_tag      <= tag;
                  fill_slot     <= victim;
                  valid[victim] <= 1'b0;
                  victim        <= victim + PAGES_LOG2'(1);
                  fill_count    <= '0;
                  miss_count    <= miss_count + 32'd1;
                  state         <= ST_ISSUE;
`ifdef FLASH_CACHE_PREFETCH_EN
                  pf_arm        <= 1'b0;
                  pf_fill       <= 1'b0;
               end else if (pf_arm && !miss && enable && qspi_initialised) begin
                  pf_arm <= 1'b0;
                  if (!pf_cached) begin
                     fill_tag      <= pf_tag;
                     fill_slot     <= victim;
                     valid[victim] <= 1'b0;
                     victim        <= victim + PAGES_LOG2'(1);
                     fill_count    <= '0;
                     pf_fill       <= 1'b1;
                     state         <= ST_ISSUE;
                  end
`endif
               end
            end
            ST_ISSUE: begin
               if (!enable_d) begin
                  state <= ST_IDLE;
               end else if (!qspi_busy) begin
                  qspi_changeAddress <= 1'b1;
                  qspi_address       <= {1'b0, fill_tag, {(PAGE_WORDS_LOG2 + 2){1'b0}}};
                  qspi_requestData   <= 1'b1;
                  fill_count         <= '0;
                  state              <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (!enable_d) begin
                  qspi_requestData <= 1'b0;
                  state            <= ST_IDLE;
               end else if (qspi_readDataValid) begin
                  fill_count <= fill_count + CNT_W'(1);
                  if (last_word) begin
                     qspi_requestData <= 1'b0;
                     tags[fill_slot]  <= fill_tag;
                     valid[fill_slot] <= 1'b1;
                     state            <= ST_IDLE;
`ifdef FLASH_CACHE_PREFETCH_EN
                     pf_arm           <= !pf_fill;
`endif
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Invalidate aborts any fill in flight and drops every slot
         if (inv_wr) begin
            valid              <= '0;
            state              <= ST_IDLE;
            qspi_requestData   <= 1'b0;
            qspi_changeAddress <= 1'b0;
`ifdef FLASH_CACHE_PREFETCH_EN
            pf_arm             <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_flash_page_cache.sv
// tb_flash_page_cache: directed bench with an SRAM model and a paced QSPI
// reader model whose fill word n of page base B is (B>>2)+n, so a flash
// read of byte address A must return A>>2.
`timescale 1ns/1ps

module tb_flash_page_cache;

   localparam int PW = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic        peripheralBus_we, peripheralBus_oe;
   logic [23:0] peripheralBus_address;
   logic [3:0]  peripheralBus_byteSelect;
   logic [31:0] peripheralBus_dataWrite, peripheralBus_dataRead;
   logic        peripheralBus_busy;
   logic        qspi_enable, qspi_changeAddress, qspi_requestData;
   logic [23:0] qspi_address;
   logic [31:0] qspi_readData;
   logic        qspi_readDataValid, qspi_initialised, qspi_busy;
   logic        sram_clk0, sram_csb0, sram_web0, sram_clk1, sram_csb1;
   logic [3:0]  sram_wmask0;
   logic [8:0]  sram_addr0, sram_addr1;
   logic [31:0] sram_din0, sram_dout1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   flash_page_cache dut (
      .clk(clk), .rst(rst),
      .peripheralBus_we(peripheralBus_we), .peripheralBus_oe(peripheralBus_oe),
      .peripheralBus_address(peripheralBus_address),
      .peripheralBus_byteSelect(peripheralBus_byteSelect),
      .peripheralBus_dataWrite(peripheralBus_dataWrite),
      .peripheralBus_dataRead(peripheralBus_dataRead),
      .peripheralBus_busy(peripheralBus_busy),
      .qspi_enable(qspi_enable), .qspi_address(qspi_address),
      .qspi_changeAddress(qspi_changeAddress), .qspi_requestData(qspi_requestData),
      .qspi_readData(qspi_readData), .qspi_readDataValid(qspi_readDataValid),
      .qspi_initialised(qspi_initialised), .qspi_busy(qspi_busy),
      .sram_clk0(sram_clk0), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
      .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
      .sram_clk1(sram_clk1), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
      .sram_dout1(sram_dout1)
   );

   // Dual-port SRAM model with registered read
   logic [31:0] mem [512];
   always @(posedge sram_clk0) begin
      if (!sram_csb0 && !sram_web0)
         for (int b = 0; b < 4; b++)
            if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
   end
   always @(posedge sram_clk1) begin
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
   end

   // QSPI reader model: one word every other cycle while requested
   logic [23:0] q_base;
   int          q_n;
   logic        q_run, q_tog;
   always @(posedge clk) begin
      if (rst) begin
         q_run <= 1'b0; q_tog <= 1'b0; q_n <= 0; qspi_readDataValid <= 1'b0;
      end else if (qspi_changeAddress) begin
         q_base <= qspi_address; q_n <= 0; q_run <= 1'b1; q_tog <= 1'b0;
         qspi_readDataValid <= 1'b0;
      end else if (q_run && qspi_requestData && q_n < PW && q_tog) begin
         qspi_readDataValid <= 1'b1;
         qspi_readData      <= 32'(q_base >> 2) + 32'(q_n);
         q_n   <= q_n + 1;
         q_tog <= 1'b0;
      end else begin
         qspi_readDataValid <= 1'b0;
         q_tog <= 1'b1;
      end
   end

   // Monitor: fill starts and the slot each fill lands in
   int          change_cnt = 0;
   logic [23:0] last_qaddr = '0;
   logic [1:0]  last_slot = '0;
   always @(posedge clk) begin
      if (qspi_changeAddress) begin
         change_cnt <= change_cnt + 1;
         last_qaddr <= qspi_address;
      end
      if (!sram_csb0 && !sram_web0 && sram_addr0[6:0] == 7'd0) last_slot <= sram_addr0[8:7];
   end

   // Bus read: hold oe until busy drops, return data and cycles taken
   task automatic bus_read(input logic [23:0] a, output logic [31:0] d, output int cyc);
      peripheralBus_address = a;
      peripheralBus_oe = 1'b1;
      cyc = 0;
      d = '0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         cyc++;
         if (!peripheralBus_busy) begin
            d = peripheralBus_dataRead;
            break;
         end
      end
      checks++;
      if (peripheralBus_busy) begin
         errors++;
         $display("FAIL bus_read_timeout addr=%h busy=%b required 0", a, peripheralBus_busy);
      end
      @(posedge clk); #1;
      peripheralBus_oe = 1'b0;
   endtask

   task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
      peripheralBus_address = a;
      peripheralBus_dataWrite = d;
      peripheralBus_byteSelect = 4'hF;
      peripheralBus_we = 1'b1;
      @(posedge clk); #1;
      peripheralBus_we = 1'b0;
   endtask

   task automatic wait_fill_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (qspi_requestData && n < 1000);
      checks++;
      if (qspi_requestData) begin
         errors++;
         $display("FAIL fill_done_timeout requestData=%b required 0", qspi_requestData);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] d; int cyc;
      rst = 1'b1;
      peripheralBus_we = 1'b0; peripheralBus_oe = 1'b0; peripheralBus_address = '0;
      peripheralBus_byteSelect = '0; peripheralBus_dataWrite = '0;
      qspi_initialised = 1'b1; qspi_busy = 1'b0; qspi_readData = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (peripheralBus_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b req 0", peripheralBus_busy); end
      checks++; if (peripheralBus_dataRead !== 32'd0) begin errors++; $display("FAIL rst_dataRead got %h req 0", peripheralBus_dataRead); end
      checks++; if (qspi_changeAddress !== 1'b0) begin errors++; $display("FAIL rst_changeAddress got %b req 0", qspi_changeAddress); end
      checks++; if (qspi_requestData !== 1'b0) begin errors++; $display("FAIL rst_requestData got %b req 0", qspi_requestData); end
      checks++; if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL rst_csb0 got %b req 1", sram_csb0); end
      checks++; if (sram_csb1 !== 1'b1) begin errors++; $display("FAIL rst_csb1 got %b req 1", sram_csb1); end
      checks++; if (qspi_enable !== 1'b0) begin errors++; $display("FAIL rst_enable got %b req 0", qspi_enable); end
      @(posedge clk); #1;
      bus_read(24'h800000, d, cyc);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_config got %h req 0", d); end
      checks++; if (cyc !== 1) begin errors++; $display("FAIL reg_read_cycles got %0d req 1", cyc); end
      bus_read(24'h80000C, d, cyc);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_misscount got %h req 0", d); end
   endtask

   task automatic test_disabled_miss();
      int low; logic [31:0] d; int cyc;
      for (int pass = 0; pass < 2; pass++) begin
         low = 0;
         if (pass == 1) begin
            bus_write(24'h800000, 32'd1);
            qspi_initialised = 1'b0;
         end
         peripheralBus_address = 24'h000010;
         peripheralBus_oe = 1'b1;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!peripheralBus_busy) low++;
         end
         @(posedge clk); #1;
         peripheralBus_oe = 1'b0;
         checks++; if (low !== 0) begin errors++; $display("FAIL stall_busy pass=%0d low_cycles=%0d req 0", pass, low); end
         checks++; if (change_cnt !== 0) begin errors++; $display("FAIL stall_nofill pass=%0d fills=%0d req 0", pass, change_cnt); end
      end
      qspi_initialised = 1'b1;
      bus_read(24'h80000C, d, cyc);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL stall_misscount got %h req 0", d); end
   endtask

   task automatic test_first_fill();
      logic [31:0] d; int cyc; int base;
      base = change_cnt;
      bus_read(24'h000010, d, cyc);
      checks++; if (d !== 32'd4) begin errors++; $display("FAIL fill_word4 got %h req 4", d); end
      checks++; if (change_cnt !== base + 1) begin errors++; $display("FAIL fill_pulse got %0d req %0d", change_cnt, base + 1); end
      checks++; if (last_qaddr !== 24'h000000) begin errors++; $display("FAIL fill_qaddr got %h req 000000", last_qaddr); end
      checks++; if (qspi_requestData !== 1'b1) begin errors++; $display("FAIL fill_early_release requestData=%b req 1", qspi_requestData); end
      bus_read(24'h800004, d, cyc);
      checks++; if (d !== 32'h3) begin errors++; $display("FAIL fill_status got %h req 3", d); end
      bus_read(24'h80000C, d, cyc);
      checks++; if (d !== 32'd1) begin errors++; $display("FAIL fill_misscount got %h req 1", d); end
      wait_fill_done();
   endtask

   task automatic test_hit();
      logic [31:0] d; int cyc; int base;
      base = change_cnt;
      bus_read(24'h000010, d, cyc);
      checks++; if (d !== 32'd4) begin errors++; $display("FAIL hit_data got %h req 4", d); end
      checks++; if (cyc !== 2) begin errors++; $display("FAIL hit_cycles got %0d req 2", cyc); end
      bus_read(24'h0001FC, d, cyc);
      checks++; if (d !== 32'h7F) begin errors++; $display("FAIL hit_lastword got %h req 7f", d); end
      checks++; if (cyc !== 2) begin errors++; $display("FAIL hit_lastword_cycles got %0d req 2", cyc); end
      checks++; if (change_cnt !== base) begin errors++; $display("FAIL hit_nofill got %0d req %0d", change_cnt, base); end
   endtask

   task automatic test_round_robin();
      logic [23:0] addrs [5];
      logic [1:0]  slots [5];
      logic [31:0] d; int cyc; int base;
      addrs = '{24'h000200, 24'h000400, 24'h000600, 24'h000800, 24'h000000};
      slots = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 5; i++) begin
         base = change_cnt;
         bus_read(addrs[i], d, cyc);
         checks++; if (d !== 32'(addrs[i] >> 2)) begin errors++; $display("FAIL rr_data addr=%h got %h req %h", addrs[i], d, 32'(addrs[i] >> 2)); end
         checks++; if (change_cnt !== base + 1) begin errors++; $display("FAIL rr_miss addr=%h fills=%0d req %0d", addrs[i], change_cnt, base + 1); end
         checks++; if (last_slot !== slots[i]) begin errors++; $display("FAIL rr_slot addr=%h got %0d req %0d", addrs[i], last_slot, slots[i]); end
         wait_fill_done();
      end
      bus_read(24'h000404, d, cyc);
      checks++; if (d !== 32'h101 || cyc !== 2) begin errors++; $display("FAIL rr_hit got %h/%0d req 101/2", d, cyc); end
      bus_read(24'h80000C, d, cyc);
      checks++; if (d !== 32'd6) begin errors++; $display("FAIL rr_misscount got %0d req 6", d); end
   endtask

   task automatic test_invalidate();
      logic [31:0] d; int cyc; int base;
      bus_read(24'h000200, d, cyc);
      checks++; if (d !== 32'h80) begin errors++; $display("FAIL inv_fill_data got %h req 80", d); end
      bus_write(24'h800008, 32'd0);
      @(negedge clk);
      checks++; if (qspi_requestData !== 1'b0) begin errors++; $display("FAIL inv_requestData got %b req 0", qspi_requestData); end
      @(posedge clk); #1;
      bus_read(24'h800004, d, cyc);
      checks++; if (d !== 32'h201) begin errors++; $display("FAIL inv_status got %h req 201", d); end
      base = change_cnt;
      bus_read(24'h000600, d, cyc);
      checks++; if (change_cnt !== base + 1) begin errors++; $display("FAIL inv_remiss fills=%0d req %0d", change_cnt, base + 1); end
      checks++; if (d !== 32'h180) begin errors++; $display("FAIL inv_remiss_data got %h req 180", d); end
      wait_fill_done();
   endtask

   task automatic test_enable_abort();
      logic [31:0] d; int cyc; int base;
      bus_read(24'h000800, d, cyc);
      bus_write(24'h800000, 32'd0);
      @(negedge clk);
      checks++; if (qspi_requestData !== 1'b0) begin errors++; $display("FAIL abort_requestData got %b req 0", qspi_requestData); end
      @(posedge clk); #1;
      bus_read(24'h800004, d, cyc);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL abort_status got %h req 1", d); end
      bus_write(24'h800000, 32'd1);
      base = change_cnt;
      bus_read(24'h000800, d, cyc);
      checks++; if (change_cnt !== base + 1) begin errors++; $display("FAIL abort_slot_invalid fills=%0d req %0d", change_cnt, base + 1); end
      checks++; if (d !== 32'h200) begin errors++; $display("FAIL abort_refill_data got %h req 200", d); end
      wait_fill_done();
      bus_read(24'h000800, d, cyc);
      checks++; if (cyc !== 2 || d !== 32'h200) begin errors++; $display("FAIL abort_rehit got %h/%0d req 200/2", d, cyc); end
   endtask

   task automatic test_reset_midfill();
      logic [31:0] d; int cyc; int base; int n;
      bus_read(24'h000010, d, cyc);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(!sram_csb0 && sram_addr0[6:0] == 7'd50) && n < 500);
      checks++; if (n >= 500) begin errors++; $display("FAIL midfill_word50_timeout cycles=%0d req <500", n); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (qspi_requestData !== 1'b0) begin errors++; $display("FAIL midrst_requestData got %b req 0", qspi_requestData); end
      checks++; if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL midrst_csb0 got %b req 1", sram_csb0); end
      checks++; if (qspi_enable !== 1'b0) begin errors++; $display("FAIL midrst_enable got %b req 0", qspi_enable); end
      @(posedge clk); #1;
      qspi_initialised = 1'b0;
      bus_read(24'h800004, d, cyc);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL midrst_status got %h req 0", d); end
      bus_read(24'h80000C, d, cyc);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL midrst_misscount got %h req 0", d); end
      qspi_initialised = 1'b1;
      bus_write(24'h800000, 32'd1);
      base = change_cnt;
      bus_read(24'h000010, d, cyc);
      checks++; if (change_cnt !== base + 1) begin errors++; $display("FAIL midrst_remiss fills=%0d req %0d", change_cnt, base + 1); end
      checks++; if (d !== 32'd4) begin errors++; $display("FAIL midrst_data got %h req 4", d); end
      wait_fill_done();
   endtask

   task automatic test_prefetch();
      logic [31:0] d; int cyc; int base;
      base = change_cnt;
      repeat (20) @(posedge clk);
      #1;
`ifdef FLASH_CACHE_PREFETCH_EN
      wait_fill_done();
      checks++; if (change_cnt !== base + 1) begin errors++; $display("FAIL pf_started fills=%0d req %0d", change_cnt, base + 1); end
      checks++; if (last_qaddr !== 24'h000200) begin errors++; $display("FAIL pf_qaddr got %h req 000200", last_qaddr); end
      bus_read(24'h000204, d, cyc);
      checks++; if (d !== 32'h81 || cyc !== 2) begin errors++; $display("FAIL pf_hit got %h/%0d req 81/2", d, cyc); end
      bus_read(24'h80000C, d, cyc);
      checks++; if (d !== 32'd1) begin errors++; $display("FAIL pf_misscount got %0d req 1", d); end
`else
      checks++; if (change_cnt !== base) begin errors++; $display("FAIL nopf_idle fills=%0d req %0d", change_cnt, base); end
      bus_read(24'h000204, d, cyc);
      checks++; if (d !== 32'h81) begin errors++; $display("FAIL nopf_data got %h req 81", d); end
      checks++; if (change_cnt !== base + 1) begin errors++; $display("FAIL nopf_miss fills=%0d req %0d", change_cnt, base + 1); end
      wait_fill_done();
      bus_read(24'h80000C, d, cyc);
      checks++; if (d !== 32'd2) begin errors++; $display("FAIL nopf_misscount got %0d req 2", d); end
`endif
   endtask

   initial begin
      test_reset();
      test_disabled_miss();
      test_first_fill();
      test_hit();
      test_round_robin();
      test_invalidate();
      test_enable_abort();
      test_reset_midfill();
      test_prefetch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog time=%0t limit=900000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
